sky_writeback_unit: RTL and testbench
=====================================

// Module: sky_writeback_unit
// PURPOSE
// Write-side companion of the XU register file: collects results from the XU's producers (ALU, LSU, ...)
// over valid/ready, arbitrates them onto the single register-file write port, and keeps a per-register
// pending scoreboard so issue logic can detect RAW/WAW hazards. Sits between XU functional units and the
// register file's write_enable/write_addr/write_data inputs; 1 write retired per cycle max.
// PARAMETERS
// NUM_SRC   2   number of result sources (index 0 = ALU, 1 = LSU); must be >= 2
// DATA_W    32  register data width
// ADDR_W    4   register address width (NUM_REGS = 2**ADDR_W = 16)
// PORTS
// clk            in   1               clock, all state on posedge
// reset_n        in   1               asynchronous active-low reset
// issue_valid    in   1               an instruction with destination issue_rd is issuing this cycle
// issue_rd       in   ADDR_W          destination register of issuing instruction
// issue_ready    out  1               combinational: !pending[issue_rd] (1 when issue_rd==0)
// query_rs1      in   ADDR_W          source operand 1 address for hazard check
// query_rs2      in   ADDR_W          source operand 2 address for hazard check
// rs1_busy       out  1               combinational: pending[query_rs1]
// rs2_busy       out  1               combinational: pending[query_rs2]
// src_valid      in   NUM_SRC         per-source result valid
// src_ready      out  NUM_SRC         per-source accept (one-hot or zero)
// src_rd         in   NUM_SRC*ADDR_W  per-source destination, source i at [i*ADDR_W +: ADDR_W]
// src_data       in   NUM_SRC*DATA_W  per-source result, source i at [i*DATA_W +: DATA_W]
// rf_write_enable out 1               to register file write_enable (registered)
// rf_write_addr  out  ADDR_W          to register file write_addr (registered)
// rf_write_data  out  DATA_W          to register file write_data (registered)
// wb_error       out  1               sticky: a source wrote a non-zero rd that was not pending
// BEHAVIOUR
// - Reset (async, reset_n=0): pending all 0, rf_write_enable=0, rf_write_addr=0, rf_write_data=0,
//   wb_error=0, round-robin pointer=0. Applies mid-operation; in-flight results are dropped.
// - Arbitration: round-robin among asserted src_valid, starting at pointer; grant one-hot on src_ready
//   (combinational from src_valid; ready may depend on valid, valid must not depend on ready).
//   Transfer = src_valid[i] & src_ready[i]. After transfer, pointer <= granted+1 (mod NUM_SRC); else hold.
// - No backpressure from the register file: a grant is issued every cycle any src_valid is high.
// - Sources hold valid/rd/data stable until accepted.
// - Latency: accepted in cycle N -> rf_write_enable=1 with addr/data in cycle N+1; RF captures at end of N+1.
// - rd==0 transfers: accepted (src_ready=1) but rf_write_enable stays 0 in N+1; no scoreboard effect.
// - Scoreboard: pending[r] set at edge after issue_valid & issue_ready & issue_rd==r & r!=0.
//   Cleared at the edge ending the cycle in which rf_write_enable=1 & rf_write_addr==r, so busy drops exactly
//   when the RF read port returns the new value. Set and clear same r same edge -> set wins.
// - issue_valid with issue_ready=0 is ignored (no set); caller must stall. pending[0] is constant 0.
// - Transfer to non-zero rd with pending[rd]==0 -> wb_error<=1 (sticky until reset), write still performed.
// STRUCTURE
// - Shared package sky_xu_pkg: XU_DATA_W=32, XU_REG_ADDR_W=4, XU_NUM_REGISTERS=16,
//   source index enum (SKY_SRC_ALU=0, SKY_SRC_LSU=1).
// - One sub-module: sky_rr_arbiter #(N) (req, grant, advance pointer); scoreboard and output register inline.
// TESTING
// - Reset: drive reset_n=0 mid-write -> all outputs 0, rs1_busy=0 for every query, wb_error=0.
// - Single path: issue rd=5; next cycle rs1_busy(5)=1; ALU valid rd=5 data=0xDEADBEEF ->
//   next cycle rf_write_enable=1 addr=5 data=0xDEADBEEF; cycle after, rs1_busy(5)=0.
// - Contention: issue r3,r4; ALU(r3,0x11) and LSU(r4,0x22) valid together from ptr=0 ->
//   ALU granted first, LSU next cycle; writes r3 then r4 on consecutive cycles; ptr ends at 0.
// - Fairness: both sources valid continuously for 6 cycles -> grants alternate ALU,LSU,...
// - WAW/zero: with r7 pending, issue_rd=7 -> issue_ready=0; issue_rd=0 -> issue_ready=1, no pending;
//   ALU write to rd=0 -> src_ready=1, rf_write_enable stays 0.
// - Same-edge set/clear: r9 write retiring while issue rd=9 accepted -> rs1_busy(9)=1 after edge;
//   ALU write to non-pending r12 -> wb_error=1 and stays 1.

Source files
------------

// File: rtl/sky_xu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sky_xu_pkg
// Purpose  : Shared XU definitions: register file geometry and result-source
//            indices used by the writeback path.
// Revision : 1.0 - initial release
// ============================================================================
package sky_xu_pkg;

  localparam int XU_DATA_W        = 32;
  localparam int XU_REG_ADDR_W    = 4;
  localparam int XU_NUM_REGISTERS = 2 ** XU_REG_ADDR_W;

  // Result source index into the writeback source vectors
  typedef enum logic [0:0] {
    SKY_SRC_ALU = 1'b0,
    SKY_SRC_LSU = 1'b1
  } sky_src_e;

endpackage : sky_xu_pkg
`default_nettype wire

// File: rtl/sky_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sky_rr_arbiter
// Purpose  : Round-robin arbiter. Grant is combinational from req, searching
//            upward from the priority pointer; the pointer moves to one past
//            the winner whenever a grant is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module sky_rr_arbiter
  import sky_xu_pkg::*;
#(
  parameter int N = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_grant_idx;
  logic             w_found;
  int               w_idx;

  // First requester at or after the pointer, wrapping around
  always_comb begin
    grant       = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        grant[w_idx]   = 1'b1;
        w_grant_idx    = PTR_W'(w_idx);
      end
    end
  end

  // Priority pointer: one past the last consumed grant, held otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_grant_idx == PTR_W'(N - 1)) ? '0 : w_grant_idx + PTR_W'(1);
    end
  end

endmodule : sky_rr_arbiter
`default_nettype wire

// File: rtl/sky_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : sky_writeback_unit
// Purpose  : Collects XU producer results over valid/ready, arbitrates them
//            onto the single register-file write port and tracks per-register
//            pending writes for RAW/WAW hazard detection at issue.
// Revision : 1.0 - initial release
// ============================================================================
module sky_writeback_unit
  import sky_xu_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = XU_DATA_W,
  parameter int ADDR_W  = XU_REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         query_rs1,
  input  logic [ADDR_W-1:0]         query_rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic                      wb_error
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_SRC-1:0]  w_grant;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_xfer_rd;
  logic [DATA_W-1:0]   w_xfer_data;
  logic                w_xfer_wr;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_pending_nxt;

  sky_rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (src_valid),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  // Grant is only ever raised on a valid source, so any grant is a transfer
  assign src_ready = w_grant;
  assign w_xfer    = |w_grant;

  // Select the granted source's destination and payload
  always_comb begin
    w_xfer_rd   = '0;
    w_xfer_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_xfer_rd   = src_rd[i*ADDR_W +: ADDR_W];
        w_xfer_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to r0 are accepted but never reach the register file
  assign w_xfer_wr = w_xfer && (w_xfer_rd != '0);

  // Hazard outputs; r0 is never pending so it always reads as ready
  assign issue_ready = !r_pending[issue_rd];
  assign rs1_busy    = r_pending[query_rs1];
  assign rs2_busy    = r_pending[query_rs2];

  // Set on accepted issue, clear when the write is on the RF port; set wins
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && issue_ready && (issue_rd != '0)) w_set[issue_rd] = 1'b1;
    if (rf_write_enable) w_clr[rf_write_addr] = 1'b1;
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
  end

  // Scoreboard register with r0 tied low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= {w_pending_nxt[NUM_REGS-1:1], 1'b0};
    end
  end

  // Register-file write port, one cycle after acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= w_xfer_wr;
      if (w_xfer_wr) begin
        rf_write_addr <= w_xfer_rd;
        rf_write_data <= w_xfer_data;
      end
    end
  end

  // Sticky flag for a write to a register nobody issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_error <= 1'b0;
    end else if (w_xfer_wr && !r_pending[w_xfer_rd]) begin
      wb_error <= 1'b1;
    end
  end

endmodule : sky_writeback_unit
`default_nettype wire

// File: tb/tb_sky_writeback_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sky_writeback_unit
// Purpose  : Directed scoreboard bench for sky_writeback_unit. Stimulus pushes
//            expected grants and RF writes; a monitor pops them on every
//            presented grant / write and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sky_writeback_unit;
  import sky_xu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic        issue_ready;
  logic [3:0]  query_rs1;
  logic [3:0]  query_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [1:0]  src_valid;
  logic [1:0]  src_ready;
  logic [7:0]  src_rd;
  logic [63:0] src_data;
  logic        rf_write_enable;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        wb_error;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_gnt[$];
  logic [35:0] exp_wr[$];

  sky_writeback_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .issue_ready     (issue_ready),
    .query_rs1       (query_rs1),
    .query_rs2       (query_rs2),
    .rs1_busy        (rs1_busy),
    .rs2_busy        (rs2_busy),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .src_rd          (src_rd),
    .src_data        (src_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .wb_error        (wb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] rd, input logic [31:0] d);
    src_rd[3:0]     = rd;
    src_data[31:0]  = d;
    src_valid[SKY_SRC_ALU] = 1'b1;
  endtask

  task automatic lsu(input logic [3:0] rd, input logic [31:0] d);
    src_rd[7:4]     = rd;
    src_data[63:32] = d;
    src_valid[SKY_SRC_LSU] = 1'b1;
  endtask

  // Monitor: every presented grant and RF write must match the next expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (src_valid != 2'b00) chk("grant_when_valid", {63'd0, |src_ready}, 64'd1);
      if (src_ready != 2'b00) begin
        if (exp_gnt.size() == 0) chk("unexpected_grant", {62'd0, src_ready}, 64'd0);
        else chk("grant", {62'd0, src_ready}, {62'd0, exp_gnt.pop_front()});
      end
      if (rf_write_enable) begin
        if (exp_wr.size() == 0) chk("unexpected_write", {28'd0, rf_write_addr, rf_write_data}, 64'd0);
        else chk("rf_write", {28'd0, rf_write_addr, rf_write_data}, {28'd0, exp_wr.pop_front()});
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    query_rs1   = '0;
    query_rs2   = '0;
    src_valid   = '0;
    src_rd      = '0;
    src_data    = '0;

    // Reset state
    @(negedge clk);
    chk("rst_we",    {63'd0, rf_write_enable}, 64'd0);
    chk("rst_addr",  {60'd0, rf_write_addr}, 64'd0);
    chk("rst_data",  {32'd0, rf_write_data}, 64'd0);
    chk("rst_err",   {63'd0, wb_error}, 64'd0);
    chk("rst_ready", {63'd0, issue_ready}, 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single path: issue r5, write DEADBEEF, busy drops after RF write cycle
    issue_valid = 1'b1; issue_rd = 4'd5;
    tick();
    issue_valid = 1'b0; query_rs1 = 4'd5;
    alu(4'd5, 32'hDEADBEEF);
    exp_gnt.push_back(2'b01); exp_wr.push_back({4'd5, 32'hDEADBEEF});
    @(negedge clk);
    chk("r5_busy_after_issue", {63'd0, rs1_busy}, 64'd1);
    chk("r5_issue_blocked",    {63'd0, issue_ready}, 64'd0);
    tick();
    src_valid = '0;
    @(negedge clk);
    chk("r5_busy_during_write", {63'd0, rs1_busy}, 64'd1);
    chk("r5_we",                {63'd0, rf_write_enable}, 64'd1);
    tick();
    @(negedge clk);
    chk("r5_busy_cleared", {63'd0, rs1_busy}, 64'd0);

    // Reset asserted mid-write of r6
    tick();
    issue_valid = 1'b1; issue_rd = 4'd6;
    tick();
    issue_valid = 1'b0;
    alu(4'd6, 32'h66);
    exp_gnt.push_back(2'b01); exp_wr.push_back({4'd6, 32'h66});
    tick();
    src_valid = '0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_we",   {63'd0, rf_write_enable}, 64'd0);
    chk("midrst_addr", {60'd0, rf_write_addr}, 64'd0);
    chk("midrst_data", {32'd0, rf_write_data}, 64'd0);
    exp_wr.delete();
    exp_gnt.delete();
    for (int q = 0; q < 16; q++) begin
      query_rs1 = 4'(q);
      query_rs2 = 4'(15 - q);
      @(negedge clk);
      chk("midrst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
      chk("midrst_rs2_busy", {63'd0, rs2_busy}, 64'd0);
    end
    chk("midrst_err", {63'd0, wb_error}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Contention from pointer 0: ALU first, LSU next cycle
    issue_valid = 1'b1; issue_rd = 4'd3;
    tick();
    issue_rd = 4'd4;
    tick();
    issue_valid = 1'b0; query_rs1 = 4'd3; query_rs2 = 4'd4;
    alu(4'd3, 32'h11); lsu(4'd4, 32'h22);
    exp_gnt.push_back(2'b01); exp_wr.push_back({4'd3, 32'h11});
    tick();
    src_valid[SKY_SRC_ALU] = 1'b0;
    exp_gnt.push_back(2'b10); exp_wr.push_back({4'd4, 32'h22});
    @(negedge clk);
    chk("r3_busy", {63'd0, rs1_busy}, 64'd1);
    chk("r4_busy", {63'd0, rs2_busy}, 64'd1);
    tick();
    src_valid = '0;
    @(negedge clk);
    chk("r3_cleared", {63'd0, rs1_busy}, 64'd0);
    tick();
    @(negedge clk);
    chk("r4_cleared", {63'd0, rs2_busy}, 64'd0);

    // Fairness: both valid for six cycles, rd=0 so nothing reaches the RF
    tick();
    alu(4'd0, 32'hA0); lsu(4'd0, 32'hB0);
    for (int i = 0; i < 6; i++) begin
      exp_gnt.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    src_valid = '0;
    @(negedge clk);
    chk("fair_no_write", {63'd0, rf_write_enable}, 64'd0);
    chk("fair_no_error", {63'd0, wb_error}, 64'd0);

    // WAW and r0 handling
    tick();
    issue_valid = 1'b1; issue_rd = 4'd7;
    tick();
    @(negedge clk);
    chk("r7_waw_blocked", {63'd0, issue_ready}, 64'd0);
    tick();
    issue_rd = 4'd0;
    @(negedge clk);
    chk("r0_issue_ready", {63'd0, issue_ready}, 64'd1);
    tick();
    issue_valid = 1'b0; query_rs1 = 4'd0; query_rs2 = 4'd7;
    alu(4'd0, 32'h1234);
    exp_gnt.push_back(2'b01);
    @(negedge clk);
    chk("r0_not_pending", {63'd0, rs1_busy}, 64'd0);
    chk("r7_pending",     {63'd0, rs2_busy}, 64'd1);
    tick();
    src_valid = '0;
    @(negedge clk);
    chk("r0_no_write", {63'd0, rf_write_enable}, 64'd0);
    tick();
    alu(4'd7, 32'h77);
    exp_gnt.push_back(2'b01); exp_wr.push_back({4'd7, 32'h77});
    tick();
    src_valid = '0;
    tick();
    @(negedge clk);
    chk("r7_cleared",   {63'd0, rs2_busy}, 64'd0);
    chk("r7_no_error",  {63'd0, wb_error}, 64'd0);

    // Write to non-pending r12 raises sticky error
    tick();
    alu(4'd12, 32'hC);
    exp_gnt.push_back(2'b01); exp_wr.push_back({4'd12, 32'hC});
    tick();
    src_valid = '0;
    @(negedge clk);
    chk("r12_error", {63'd0, wb_error}, 64'd1);

    // Same-edge set/clear on r9: set wins
    tick();
    alu(4'd9, 32'h99);
    exp_gnt.push_back(2'b01); exp_wr.push_back({4'd9, 32'h99});
    tick();
    src_valid = '0;
    issue_valid = 1'b1; issue_rd = 4'd9;
    @(negedge clk);
    chk("r9_issue_ready", {63'd0, issue_ready}, 64'd1);
    chk("r9_retiring",    {63'd0, rf_write_enable}, 64'd1);
    tick();
    issue_valid = 1'b0; query_rs1 = 4'd9;
    @(negedge clk);
    chk("r9_set_wins",    {63'd0, rs1_busy}, 64'd1);
    chk("error_sticky",   {63'd0, wb_error}, 64'd1);

    repeat (3) tick();
    chk("grant_queue_drained", 64'(exp_gnt.size()), 64'd0);
    chk("write_queue_drained", 64'(exp_wr.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sky_writeback_unit
`default_nettype wire
